mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the CPU's single shared 32-bit memory port. Instruction fetch (requester 0) and load/store (requester 1) each issue word transactions through a req/gnt/rvalid handshake. The block selects one requester round-robin, registers its address/data into the port, and holds the port until memory signals completion or a timeout expires. It then returns read data or a write acknowledge to the winning requester.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes and the shared memory port.
// master = requesters plus memory (the environment); slave = the arbiter.
interface mem_port_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        we0;
    logic        we1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit memory port: fetch (0)
// and load/store (1) take turns; each transaction ends on mem_ready or timeout.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned    CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          win;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // On a tie the requester not served last wins; a lone request always wins.
        win = bus.req1 & (~bus.req0 | ~last_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d     = ST_BUSY;
                    owner_d     = win;
                    last_d      = win;
                    cnt_d       = CNT_ONE;
                    gnt_d       = win ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win ? bus.we1    : bus.we0;
                    mem_addr_d  = win ? bus.addr1  : bus.addr0;
                    mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_d  = ST_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    rvalid_d = owner_q ? 2'b10 : 2'b01;
                    if (!mem_we_q) begin
                        if (owner_q) rdata1_d = bus.mem_rdata;
                        else         rdata0_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    rvalid_d = owner_q ? 2'b10 : 2'b01;
                    err_d    = owner_q ? 2'b10 : 2'b01;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbitration and completion rules.
module tb_mem_port_arbiter;
    localparam int MW = 4;

    logic clk;
    logic reset_n;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_WAIT(MW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          m_last;
    logic [31:0] m_rdata [2];
    logic [1:0]  obs_gnt;

    function automatic logic [1:0] gnt_v();
        return {bus.gnt1, bus.gnt0};
    endfunction
    function automatic logic [1:0] rvalid_v();
        return {bus.rvalid1, bus.rvalid0};
    endfunction
    function automatic logic [1:0] err_v();
        return {bus.err1, bus.err0};
    endfunction

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
    endtask

    // One transaction: the model picks the winner, the memory answers in BUSY
    // cycle lat+1 (or never, if that exceeds MW), and every cycle is checked.
    task automatic do_txn(input logic r0, input logic r1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic w0, input logic w1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int lat, input logic [31:0] rd);
        int          w;
        logic [1:0]  exp_g;
        logic [31:0] ea, ed;
        logic        ewe, ready, done, terr;
        int          k;
        bus.req0 = r0; bus.req1 = r1;
        bus.addr0 = a0; bus.addr1 = a1; bus.we0 = w0; bus.we1 = w1;
        bus.wdata0 = d0; bus.wdata1 = d1; bus.mem_ready = 0;
        if (r0 && r1) w = 1 - m_last;
        else          w = r1 ? 1 : 0;
        m_last = w;
        exp_g = (w == 1) ? 2'b10 : 2'b01;
        ea  = (w == 1) ? a1 : a0;
        ed  = (w == 1) ? d1 : d0;
        ewe = (w == 1) ? w1 : w0;
        @(posedge clk); #1;
        obs_gnt = gnt_v();
        checks++;
        if (gnt_v() !== exp_g || bus.mem_en !== 1'b1 || rvalid_v() !== 2'b00)
            $display("FAIL grant: gnt=%b mem_en=%b rvalid=%b, expected gnt=%b mem_en=1 rvalid=00",
                     gnt_v(), bus.mem_en, rvalid_v(), exp_g);
        checks++;
        if (bus.mem_addr !== ea || bus.mem_we !== ewe || bus.mem_wdata !== ed) begin
            errors++;
            $display("FAIL port_capture: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, ea, ewe, ed);
        end
        if (gnt_v() !== exp_g || bus.mem_en !== 1'b1 || rvalid_v() !== 2'b00) errors++;
        if (w == 1) bus.req1 = 0; else bus.req0 = 0;
        done = 0;
        k = 1;
        while (!done) begin
            ready = (k == lat + 1);
            bus.mem_ready = ready;
            bus.mem_rdata = ready ? rd : $urandom;
            done = ready || (k == MW);
            terr = !ready && (k == MW);
            if (ready && !ewe) m_rdata[w] = rd;
            @(posedge clk); #1;
            bus.mem_ready = 0;
            if (done) begin
                checks++;
                if (rvalid_v() !== exp_g || err_v() !== (terr ? exp_g : 2'b00) ||
                    bus.mem_en !== 1'b0 || gnt_v() !== 2'b00) begin
                    errors++;
                    $display("FAIL completion: rvalid=%b err=%b mem_en=%b gnt=%b, expected rvalid=%b err=%b mem_en=0 gnt=00",
                             rvalid_v(), err_v(), bus.mem_en, gnt_v(), exp_g, terr ? exp_g : 2'b00);
                end
                checks++;
                if (bus.rdata0 !== m_rdata[0] || bus.rdata1 !== m_rdata[1]) begin
                    errors++;
                    $display("FAIL rdata: rdata0=%h rdata1=%h, expected %h %h",
                             bus.rdata0, bus.rdata1, m_rdata[0], m_rdata[1]);
                end
            end else begin
                checks++;
                if (gnt_v() !== 2'b00 || rvalid_v() !== 2'b00 || bus.mem_en !== 1'b1 ||
                    bus.mem_addr !== ea || bus.mem_we !== ewe || bus.mem_wdata !== ed) begin
                    errors++;
                    $display("FAIL busy_cycle%0d: gnt=%b rvalid=%b mem_en=%b addr=%h we=%b wdata=%h, expected 00 00 1 %h %b %h",
                             k, gnt_v(), rvalid_v(), bus.mem_en, bus.mem_addr, bus.mem_we,
                             bus.mem_wdata, ea, ewe, ed);
                end
            end
            k++;
        end
    endtask

    task automatic idle_cycles(input int n, input bit noise_ones);
        bus.req0 = 0; bus.req1 = 0;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = noise_ones ? 1'b1 : 1'($urandom);
            bus.mem_rdata = noise_ones ? 32'hFFFF_FFFF : $urandom;
            @(posedge clk); #1;
            checks++;
            if (bus.mem_en !== 1'b0 || gnt_v() !== 2'b00 || rvalid_v() !== 2'b00 ||
                err_v() !== 2'b00 || bus.rdata0 !== m_rdata[0] || bus.rdata1 !== m_rdata[1]) begin
                errors++;
                $display("FAIL idle: mem_en=%b gnt=%b rvalid=%b err=%b rdata0=%h rdata1=%h, expected 0 00 00 00 %h %h",
                         bus.mem_en, gnt_v(), rvalid_v(), err_v(), bus.rdata0, bus.rdata1,
                         m_rdata[0], m_rdata[1]);
            end
        end
        bus.mem_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_en !== 0 || bus.mem_we !== 0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
            gnt_v() !== 0 || rvalid_v() !== 0 || err_v() !== 0 ||
            bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            errors++;
            $display("FAIL reset_values: mem_en=%b we=%b addr=%h wdata=%h gnt=%b rvalid=%b err=%b rd0=%h rd1=%h, expected all zero",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, gnt_v(), rvalid_v(),
                     err_v(), bus.rdata0, bus.rdata1);
        end
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_txn(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
        checks++;
        if (bus.rdata0 !== 32'hDEAD_BEEF || bus.err0 !== 1'b0) begin
            errors++;
            $display("FAIL single_read: rdata0=%h err0=%b, expected deadbeef 0", bus.rdata0, bus.err0);
        end
    endtask

    task automatic test_single_write();
        do_txn(0, 1, 32'h0, 32'h200, 0, 1, 32'h0, 32'h1234_5678, 3, 32'hA5A5_A5A5);
        checks++;
        if (bus.rdata1 !== 32'h0 || bus.err1 !== 1'b0) begin
            errors++;
            $display("FAIL single_write: rdata1=%h err1=%b, expected 0 0", bus.rdata1, bus.err1);
        end
    endtask

    task automatic test_tie_fairness();
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, '0, '0,
                   $urandom_range(0, 1), $urandom);
            checks++;
            if (obs_gnt !== seq[i]) begin
                errors++;
                $display("FAIL tie_order%0d: gnt=%b, expected %b", i, obs_gnt, seq[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_txn(1, 0, 32'h300, 32'h0, 0, 0, '0, '0, MW, 32'h5555_AAAA);
        checks++;
        if (bus.err0 !== 1'b1 || bus.rdata0 === 32'h5555_AAAA) begin
            errors++;
            $display("FAIL timeout: err0=%b rdata0=%h, expected err0=1 and rdata0 unchanged", bus.err0, bus.rdata0);
        end
        do_txn(0, 1, 32'h0, 32'h304, 0, 0, '0, '0, MW - 1, 32'h0BAD_F00D);
        checks++;
        if (bus.err1 !== 1'b0 || bus.rdata1 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL last_cycle_ready: err1=%b rdata1=%h, expected 0 0badf00d", bus.err1, bus.rdata1);
        end
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1; bus.req1 = 0; bus.addr0 = 32'h400; bus.we0 = 0; bus.mem_ready = 0;
        @(posedge clk); #1;
        bus.req0 = 0;
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: gnt0=%b mem_en=%b, expected 1 1", bus.gnt0, bus.mem_en);
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
        checks++;
        if (bus.mem_en !== 1'b0 || rvalid_v() !== 2'b00 || err_v() !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: mem_en=%b rvalid=%b err=%b, expected 0 00 00",
                     bus.mem_en, rvalid_v(), err_v());
        end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        idle_cycles(3, 0);
        do_txn(1, 1, 32'h500, 32'h600, 0, 0, '0, '0, 0, 32'h1111_2222);
        checks++;
        if (obs_gnt !== 2'b01) begin
            errors++;
            $display("FAIL tie_after_reset: gnt=%b, expected 01", obs_gnt);
        end
    endtask

    task automatic test_idle_noise();
        idle_cycles(4, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2), 0);
            do_txn(r[0], r[1], $urandom, $urandom, 1'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom_range(0, MW), $urandom);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        obs_gnt = 2'b00;
        test_reset();
        test_single_read();
        test_single_write();
        test_tie_fairness();
        test_timeout();
        test_idle_noise();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
